// File: rtl/rr_serial_arbiter.sv
// Round-robin arbiter and transaction sequencer for the serial bus.
// It grants one serial master, shifts in that master's slave address (MSB first)
// and hands it to the decoder. It then holds the bus until the slave finishes or
// the watchdog expires.
module rr_serial_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_tx,
  output logic [NUM_MASTERS-1:0] m_rx,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ADDR_W-1:0]      addr,
  output logic                   addr_rdy,
  input  logic                   slv_ready,
  input  logic                   slv_responded,
  output logic                   timeout,
  output logic [2:0]             state_o
);

  localparam int GW   = $clog2(NUM_MASTERS);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int BC_W = $clog2(ADDR_W + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(ADDR_W - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT    = 3'd1,
    S_ADDR     = 3'd2,
    S_WAIT_SLV = 3'd3,
    S_BUSY     = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [GW-1:0]            owner, last_grant, pick, cand;
  logic                     pick_vld;
  logic [WD_W-1:0]          wd;
  logic [BC_W-1:0]          bit_cnt;
  logic [ADDR_W-1:0]        addr_sh;
  logic [NUM_MASTERS-1:0]   owner_oh;
  logic                     owner_bit, addr_last, wd_expired;
  logic                     release_c, abort_c;
  int                       j;

  // Append one serial bit below the bits already received (MSB arrives first).
  function automatic logic [ADDR_W-1:0] shift_in(input logic [ADDR_W-1:0] cur, input logic b);
    return ADDR_W'({cur, b});
  endfunction

  // Watchdog increment that sticks at all-ones instead of wrapping.
  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
    return (v == '1) ? v : v + WD_W'(1);
  endfunction

  assign owner_oh   = NUM_MASTERS'(1) << owner;
  assign owner_bit  = m_tx[owner];
  assign addr_last  = (state == S_ADDR) && (bit_cnt == BC_LAST);
  assign wd_expired = (wd >= WD_LIMIT);
  assign state_o    = state;

  // Round-robin search: the nearest requester after last_grant (wrapping) wins.
  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    j        = 0;
    cand     = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      j = int'(last_grant) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      cand = GW'(j);
      if (!m_tx[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state decode; slave handshakes take priority over the watchdog.
  always_comb begin
    state_nxt = state;
    release_c = 1'b0;
    abort_c   = 1'b0;
    case (state)
      S_IDLE:     if (pick_vld) state_nxt = S_GRANT;
      S_GRANT:    state_nxt = S_ADDR;
      S_ADDR:     if (addr_last) state_nxt = S_WAIT_SLV;
      S_WAIT_SLV: begin
        if (slv_ready && slv_responded) release_c = 1'b1;
        else if (slv_ready)             state_nxt = S_BUSY;
        else if (wd_expired)            abort_c   = 1'b1;
      end
      S_BUSY: begin
        if (slv_responded)   release_c = 1'b1;
        else if (wd_expired) abort_c   = 1'b1;
      end
      default:    state_nxt = S_IDLE;
    endcase
    if (release_c || abort_c) state_nxt = S_IDLE;
  end

  // Bus ownership and the one-cycle grant pulse follow the current state.
  always_comb begin
    grant = '0;
    m_rx  = '0;
    case (state)
      S_GRANT: begin
        grant = owner_oh;
        m_rx  = owner_oh;
      end
      S_ADDR, S_WAIT_SLV, S_BUSY: grant = owner_oh;
      default: ;
    endcase
  end

  // Control state, counters and decoder-facing outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);
      wd         <= '0;
      bit_cnt    <= '0;
      addr       <= '0;
      addr_rdy   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state    <= state_nxt;
      timeout  <= abort_c;
      addr_rdy <= 1'b0;
      if (state == S_IDLE && pick_vld) owner <= pick;
      if (release_c || abort_c) last_grant <= owner;
      if (state == S_ADDR) bit_cnt <= bit_cnt + BC_W'(1);
      else                 bit_cnt <= '0;
      if (addr_last) begin
        addr     <= shift_in(addr_sh, owner_bit);
        addr_rdy <= 1'b1;
      end
      if (state_nxt != state)
        wd <= '0;
      else if (state == S_WAIT_SLV || state == S_BUSY)
        wd <= wd_sat_inc(wd);
    end
  end

  // Address shift register; every bit is overwritten before it is used.
  always_ff @(posedge clk) begin
    if (state == S_ADDR) addr_sh <= shift_in(addr_sh, owner_bit);
  end

endmodule

// File: doc/rr_serial_arbiter.md
Name: rr_serial_arbiter

Overview:
- Round-robin bus arbiter and transaction sequencer for the serial bus, parameterised for NUM_MASTERS serial masters.
- Detects serial requests and grants one master. Shifts in that master's serial slave address, presents it to the address decoder, then holds the bus until the slave completes or a watchdog expires.
- Its m_rx outputs feed the per-master read muxes as the arbiter-data input.

Parameters:
- NUM_MASTERS, 2: number of serial masters; legal range 2..8.
- ADDR_W, 2: slave address width in bits, shifted MSB first.
- TIMEOUT, 255: maximum cycles to wait in WAIT_SLV or BUSY before abort; legal range 2..65535.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- m_tx  input  NUM_MASTERS  master serial tx lines; idle 1; 0 in IDLE = request.
- m_rx  output  NUM_MASTERS  arbiter-to-master serial lines; a 1-cycle high pulse on bit g = grant.
- grant  output  NUM_MASTERS  one-hot bus ownership; all-zero when no owner.
- addr  output  ADDR_W  captured slave address; valid when addr_rdy=1; held until next capture.
- addr_rdy  output  1  1-cycle pulse: addr is valid for the decoder.
- slv_ready  input  1  decoder: addressed slave exists and is connected.
- slv_responded  input  1  decoder: slave transaction finished.
- timeout  output  1  1-cycle pulse: transaction aborted by the watchdog.
- state_o  output  3  current FSM state; encoding below.

Behaviour:
- Reset: all outputs 0. state_o=IDLE, addr=0, counters 0, last_grant=NUM_MASTERS-1 so master 0 wins the first contest.
  - Reset asserted mid-transaction aborts immediately.
  - No timeout pulse is generated on reset.
- State encoding: IDLE=0, GRANT=1, ADDR=2, WAIT_SLV=3, BUSY=4. Any other value returns to IDLE.
- IDLE:
  - grant=0.
  - Requests are the set of masters with m_tx==0 in the current cycle.
  - If any request exists, pick the first requester searching upward from last_grant+1, wrapping modulo NUM_MASTERS.
  - Next cycle: enter GRANT, grant=onehot(g), m_rx[g]=1.
- GRANT: lasts exactly 1 cycle; m_rx[g]=1 only in this cycle. Next state is ADDR with the bit counter cleared.
- ADDR:
  - Lasts exactly ADDR_W cycles.
  - Each cycle, shift m_tx[g] into the address shift register, MSB first.
  - The master drives address MSB on the cycle after it sees the m_rx pulse.
  - After the last bit, enter WAIT_SLV: addr updates and addr_rdy=1 in the first WAIT_SLV cycle only.
- WAIT_SLV:
  - The watchdog is cleared on entry and increments each cycle.
  - slv_ready=1 → BUSY with the watchdog cleared.
  - slv_ready=1 and slv_responded=1 in the same cycle → release directly.
  - Watchdog reaches TIMEOUT-1 with no slv_ready → abort.
  - If slv_ready and the timeout condition fall on the same cycle, slv_ready wins.
- BUSY:
  - Wait for slv_responded=1 → release.
  - Watchdog reaches TIMEOUT-1 with no slv_responded → abort; slv_responded wins if simultaneous.
  - grant stays asserted throughout. m_tx[g] carries payload and is ignored by the arbiter.
- Release: next cycle IDLE, grant=0, last_grant=g.
- Abort: same as release, plus timeout=1 for exactly the first IDLE cycle.
- Requests are not re-evaluated in the release cycle. A minimum of 1 IDLE cycle separates transactions, and a request seen in that IDLE cycle is granted in the following cycle.
- Non-owner m_tx lines are ignored outside IDLE.
- Watchdog width is $clog2(TIMEOUT+1); it saturates and never wraps.
- m_rx bits other than the grant pulse are always 0.

Test Plan:
- Reset then m_tx=2'b10 (m0 requests):
  - grant=01 and m_rx=01 one cycle after the request is seen.
  - m0 shifts address 2'b10 → addr=2, addr_rdy pulse after 2 ADDR cycles.
  - slv_ready, then slv_responded 5 cycles later → grant=0, state_o=0.
- Both masters hold m_tx=0 continuously over 4 transactions → grants alternate m0, m1, m0, m1. There is exactly 1 IDLE cycle between each, and each m_rx pulse is 1 cycle.
- Grant m1, address 2'b11, slv_ready never asserted:
  - timeout pulse exactly 255 cycles after entering WAIT_SLV, grant=0.
  - Next contest with both requesting → m0 wins.
- In WAIT_SLV, drive slv_ready=1 on watchdog count 254 (the timeout cycle) → BUSY, no timeout pulse. In WAIT_SLV, drive slv_ready=1 and slv_responded=1 together → direct release, BUSY never visited.
- Deassert rstn asynchronously mid-BUSY → grant, m_rx, addr, addr_rdy and timeout all 0 immediately, state_o=0. After reset release, m1 requesting alone is granted normally.
- NUM_MASTERS=3, ADDR_W=3, TIMEOUT=4:
  - All three request; last_grant=2 → m0 granted.
  - Address 3'b101 captured as addr=5.
  - Watchdog abort after 4 cycles in BUSY → timeout pulse; subsequent grant goes to m1.
